// File: rtl/dense_layer_engine.sv
// Dense-layer engine: per neuron, bias + MAC over the input vector, scale by 1/256,
// then tanh/sigmoid (linearly interpolated LUT), relu or linear activation.
module dense_layer_engine #(
  parameter int FIXED  = 32,
  parameter int ADDR_W = 16,
  parameter int VEC_AW = 7,
  parameter int LUT_AW = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        nb_inputs,
  input  logic [7:0]        nb_neurons,
  input  logic [1:0]        act_sel,
  input  logic [ADDR_W-1:0] w_base,
  input  logic [ADDR_W-1:0] b_base,
  output logic [ADDR_W-1:0] m_addr,
  input  logic [FIXED-1:0]  m_data,
  output logic [VEC_AW-1:0] x_addr,
  input  logic [FIXED-1:0]  x_data,
  output logic [LUT_AW-1:0] lut_addr,
  input  logic [FIXED-1:0]  lut_data,
  output logic              y_we,
  output logic [VEC_AW-1:0] y_addr,
  output logic [FIXED-1:0]  y_data,
  output logic              busy,
  output logic              valid
);

  localparam int FRAC = 16;
  localparam logic [FIXED-1:0] ONE  = FIXED'(1) << FRAC;
  localparam logic [FIXED-1:0] HALF = FIXED'(1) << (FRAC - 1);

  typedef enum logic [3:0] {IDLE, BIAS, MAC, DRAIN, SCALE, LUT0, LUT1, ACT, DONE} state_t;

  state_t state_q, state_d;

  logic [7:0]        m_q, nn_q, n_q, i_q;
  logic [1:0]        act_q;
  logic [ADDR_W-1:0] w_base_q, b_base_q, w_ptr_q;
  logic [FIXED-1:0]  acc_q, s_q, t_q, l0_q;

  logic [2*FIXED-1:0] prod_w;
  logic [FIXED-1:0]   prod_mid_w, s_w;
  logic [FIXED-1:0]   u_w, mag_w, tv_w, y_w;
  logic [LUT_AW-1:0]  idx0_w, idx1_w;
  logic [7:0]         f_w;
  logic [FIXED+9:0]   mix_w;
  logic               clamp_w;
  logic               unused_bits;

  assign prod_w     = $signed(m_data) * $signed(x_data);
  assign prod_mid_w = prod_w[FIXED+FRAC-1:FRAC];
  assign s_w        = $unsigned($signed(acc_q) >>> 8);
  assign unused_bits = ^{prod_w[2*FIXED-1:FIXED+FRAC], prod_w[FRAC-1:0],
                         mix_w[FIXED+9:FIXED+8], mix_w[7:0]};

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (nb_neurons == 8'd0) ? DONE : BIAS;
      BIAS:    state_d = (m_q == 8'd0) ? DRAIN : MAC;
      MAC:     if (i_q == m_q - 8'd1) state_d = DRAIN;
      DRAIN:   state_d = SCALE;
      SCALE:   state_d = LUT0;
      LUT0:    state_d = LUT1;
      LUT1:    state_d = ACT;
      ACT:     state_d = (n_q == nn_q - 8'd1) ? DONE : BIAS;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath registers; read data always refers to the address issued one cycle earlier
  always_ff @(posedge clk) begin
    if (rst) begin
      m_q <= '0; nn_q <= '0; n_q <= '0; i_q <= '0; act_q <= '0;
      w_base_q <= '0; b_base_q <= '0; w_ptr_q <= '0;
      acc_q <= '0; s_q <= '0; t_q <= '0; l0_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          m_q      <= nb_inputs;
          nn_q     <= nb_neurons;
          act_q    <= act_sel;
          w_base_q <= w_base;
          b_base_q <= b_base;
          n_q      <= '0;
        end
        BIAS: begin
          i_q     <= '0;
          w_ptr_q <= w_base_q + {{(ADDR_W-8){1'b0}}, n_q};
        end
        MAC: begin
          i_q     <= i_q + 8'd1;
          w_ptr_q <= w_ptr_q + {{(ADDR_W-8){1'b0}}, nn_q};
          acc_q   <= (i_q == 8'd0) ? m_data : acc_q + prod_mid_w;
        end
        DRAIN: acc_q <= (m_q == 8'd0) ? m_data : acc_q + prod_mid_w;
        SCALE: begin
          s_q <= s_w;
          t_q <= (act_q == 2'd1) ? $unsigned($signed(s_w) >>> 1) : s_w;
        end
        LUT1: l0_q <= lut_data;
        ACT:  n_q <= n_q + 8'd1;
        default: ;
      endcase
    end
  end

  // Activation: interpolate between L0 and L1 with the 8 fractional index bits
  always_comb begin
    u_w     = t_q[FIXED-1] ? -t_q : t_q;
    f_w     = u_w[7:0];
    idx0_w  = u_w[LUT_AW+7:8];
    idx1_w  = (&idx0_w) ? idx0_w : idx0_w + LUT_AW'(1);
    clamp_w = |u_w[FIXED-1:LUT_AW+8];
    mix_w   = {10'd0, l0_q} * {{(FIXED+1){1'b0}}, 9'd256 - {1'b0, f_w}}
            + {10'd0, lut_data} * {{(FIXED+2){1'b0}}, f_w};
    mag_w   = clamp_w ? ONE : mix_w[FIXED+7:8];
    tv_w    = t_q[FIXED-1] ? -mag_w : mag_w;
    case (act_q)
      2'd0:    y_w = tv_w;
      2'd1:    y_w = $unsigned($signed(tv_w) >>> 1) + HALF;
      2'd2:    y_w = s_q[FIXED-1] ? '0 : s_q;
      default: y_w = s_q;
    endcase
  end

  // Output logic
  always_comb begin
    m_addr   = '0;
    x_addr   = '0;
    lut_addr = '0;
    y_we     = 1'b0;
    y_addr   = '0;
    y_data   = '0;
    busy     = (state_q != IDLE) && (state_q != DONE);
    valid    = (state_q == DONE);
    case (state_q)
      BIAS: m_addr = b_base_q + {{(ADDR_W-8){1'b0}}, n_q};
      MAC: begin
        m_addr = w_ptr_q;
        x_addr = i_q[VEC_AW-1:0];
      end
      LUT0: lut_addr = idx0_w;
      LUT1: lut_addr = idx1_w;
      ACT: begin
        y_we   = 1'b1;
        y_addr = n_q[VEC_AW-1:0];
        y_data = y_w;
      end
      default: ;
    endcase
  end

endmodule
